imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int HDR_BYTES = 2;
  localparam int CSUM_W    = 8;
  localparam int LEN_W     = HDR_BYTES * 8;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed image into instruction memory one byte write per payload byte.
// Writes are registered (one cycle after accept); in_ready is low outside the load states, so the source stalls.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MEM_BYTES);

  loader_state_t     state, state_nxt;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  len, cnt, cnt_inc, len_in;
  logic [CSUM_W-1:0] csum;
  logic [ADDR_W-1:0] addr;
  logic              accept;

  assign accept  = in_valid & in_ready;
  assign len_in  = {in_data, len_lo};
  assign cnt_inc = cnt + LEN_W'(1);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    core_hold = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LEN_LO;
      end
      DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
        if (start) state_nxt = LEN_LO;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          // Oversized images are rejected before any byte lands in memory.
          if ({1'b0, len_in} > MAX_LEN)  state_nxt = ERROR;
          else if (len_in == '0)         state_nxt = CHECK;
          else                           state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && cnt_inc == len) state_nxt = CHECK;
      end
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nxt = (in_data == csum) ? DONE : ERROR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      len_lo  <= '0;
      len     <= '0;
      cnt     <= '0;
      csum    <= '0;
      addr    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            len_lo <= '0;
            len    <= '0;
            cnt    <= '0;
            csum   <= '0;
            addr   <= '0;
          end
        end
        LEN_LO:  if (accept) len_lo <= in_data;
        LEN_HI:  if (accept) len <= len_in;
        PAYLOAD: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= in_data;
            addr    <= addr + ADDR_W'(1);
            csum    <= csum + in_data;
            cnt     <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
